sign_unit: RTL and testbench
============================

# sign_unit

Two's-complement sign extractor for the CORDIC vectoring datapath. It reports the sign bit of a signed word combinationally, for rotation-direction decisions within the same cycle. It also provides a registered, valid-qualified copy of the sign plus zero and magnitude flags for pipelined stages. The block sits between the Y-residual register and the micro-rotation direction logic.

## Interface
- WORD_WIDTH, 16: width of the signed input word (≥2).
- clk  input  1: single clock; all registers update on the rising edge.
- rst  input  1: synchronous, active-high reset.
- ans  input  WORD_WIDTH: signed two's-complement value under test.
- in_valid  input  1: ans is valid this cycle; capture it into the registered outputs.
- sign_ans  output  1: combinational sign, equal to ans[WORD_WIDTH-1]. Has no dependence on clk or rst.
- out_valid  output  1: registered copy of in_valid.
- sign_q  output  1: registered sign of the last captured ans.
- zero_q  output  1: registered flag, 1 when the last captured ans == 0.
- abs_q  output  WORD_WIDTH: registered magnitude of the last captured ans, as an unsigned value.

## Operation
- sign_ans = ans[WORD_WIDTH-1] at all times, with pure combinational propagation.
  - 1 means negative. 0 means zero or positive.
  - No X-masking. It must be valid even if clk never toggles or rst is never asserted.
- When in_valid = 1 at a rising edge, the block registers:
  - sign_q ← ans[WORD_WIDTH-1]
  - zero_q ← (ans == 0)
  - abs_q ← ans when the MSB is 0, otherwise (~ans + 1) truncated to WORD_WIDTH bits.
- Most-negative input (MSB = 1, all other bits 0): abs_q = 2^(WORD_WIDTH-1) as unsigned. There is no saturation and no error flag.
- Zero is non-negative: sign_q = 0, zero_q = 1, abs_q = 0.
- When in_valid = 0 at an edge, sign_q, zero_q and abs_q hold their previous values. out_valid ← 0.
- out_valid ← in_valid every cycle. There is no backpressure and no ready signal; the block accepts one word per cycle.

## Timing
- sign_ans: 0-cycle latency (combinational).
- sign_q, zero_q, abs_q, out_valid: 1-cycle latency. They reflect the ans/in_valid sampled at the preceding rising edge.
- Reset (rst = 1 at a rising edge):
  - out_valid = 0, sign_q = 0, zero_q = 1, abs_q = 0.
  - in_valid is ignored in that cycle.
- Reset asserted mid-stream discards the in-flight word. After rst deasserts, the first captured word appears one cycle after its in_valid edge.
- sign_ans is unaffected by rst.
- Back-to-back in_valid produces back-to-back out_valid, with each result aligned to its own input.

## Test plan
- Combinational sweep, WORD_WIDTH = 16, no clock, 2 ns per vector, sign_ans expected:
  - 0x0F50 → 0, 0xFF50 → 1, 0xFFFF → 1, 0x7FFF → 0
  - 0x8000 → 1, 0x0000 → 0, 0xAAAA → 1, 0x55A5 → 0
- Reset: assert rst for 2 cycles with in_valid = 1 and ans = 0xFFFF → out_valid = 0, sign_q = 0, zero_q = 1, abs_q = 0. sign_ans stays 1 throughout.
- Registered path, back-to-back inputs:
  - in_valid = 1, ans = 0xFF50 then 0x0F50.
  - Next cycles: (sign_q, zero_q, abs_q) = (1, 0, 0x00B0), then (0, 0, 0x0F50), with out_valid = 1 both cycles.
- Boundaries:
  - ans = 0x8000 → sign_q = 1, abs_q = 0x8000.
  - ans = 0x0000 → zero_q = 1, sign_q = 0.
  - ans = 0x7FFF → abs_q = 0x7FFF.
- Hold: in_valid = 0 for 3 cycles after capturing 0xAAAA → out_valid = 0. sign_q, zero_q, abs_q (1, 0, 0x5556) are held while ans changes.
- Mid-stream reset: rst = 1 for one cycle between two valid words → the word sampled during reset is dropped. The next word appears one cycle later with out_valid = 1.

Source files
------------

// File: rtl/sign_unit.sv
// rtl/sign_unit.sv - two's-complement sign extractor with registered sign/zero/magnitude flags
module sign_unit #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] ans,
  input  logic                  in_valid,
  output logic                  sign_ans,
  output logic                  out_valid,
  output logic                  sign_q,
  output logic                  zero_q,
  output logic [WORD_WIDTH-1:0] abs_q
);

  logic                  w_sign;
  logic                  w_zero;
  logic [WORD_WIDTH-1:0] w_neg;
  logic [WORD_WIDTH-1:0] w_abs;

  logic                  r_out_valid;
  logic                  r_sign;
  logic                  r_zero;
  logic [WORD_WIDTH-1:0] r_abs;

  // The direction logic consumes this in the same cycle, so it never touches clk or rst.
  assign w_sign   = ans[WORD_WIDTH-1];
  assign sign_ans = w_sign;

  assign w_zero = (ans == '0);
  // Most-negative input wraps to itself, which reads back as 2^(WORD_WIDTH-1) unsigned.
  assign w_neg  = ~ans + WORD_WIDTH'(1);
  assign w_abs  = w_sign ? w_neg : ans;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b1;
      r_abs       <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sign <= w_sign;
        r_zero <= w_zero;
        r_abs  <= w_abs;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sign_q    = r_sign;
  assign zero_q    = r_zero;
  assign abs_q     = r_abs;

endmodule

// File: tb/tb_sign_unit.sv
// tb/tb_sign_unit.sv - randomized scoreboard bench for sign_unit
module tb_sign_unit;

  localparam int W = 16;

  typedef struct {
    logic         sign;
    logic         zero;
    logic [W-1:0] abs;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] ans;
  logic         in_valid;
  logic         sign_ans;
  logic         out_valid;
  logic         sign_q;
  logic         zero_q;
  logic [W-1:0] abs_q;

  int   n_cmp;
  int   n_err;
  bit   clk_run;
  bit   mon_en;
  logic edge_rst;
  exp_t sb_q[$];
  exp_t hold;

  sign_unit #(.WORD_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ans      (ans),
    .in_valid (in_valid),
    .sign_ans (sign_ans),
    .out_valid(out_valid),
    .sign_q   (sign_q),
    .zero_q   (zero_q),
    .abs_q    (abs_q)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: magnitude from plain signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a);
    exp_t e;
    int   s;
    s      = int'($signed(a));
    e.sign = (s < 0);
    e.zero = (s == 0);
    e.abs  = W'((s < 0) ? -s : s);
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [W-1:0] a);
    rst      = r;
    in_valid = v;
    ans      = a;
    @(posedge clk);
    if (!r && v) sb_q.push_back(model(a));
    #1;
  endtask

  always @(posedge clk) edge_rst = rst;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("sign_ans_live", W'(sign_ans), W'(ans[W-1]));
      if (edge_rst === 1'b1) begin
        sb_q.delete();
        hold.sign = 1'b0;
        hold.zero = 1'b1;
        hold.abs  = '0;
        chk("reset_out_valid", W'(out_valid), '0);
      end else if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out_valid: actual=1 required=0 at %0t", $time);
        end else begin
          e    = sb_q.pop_front();
          hold = e;
        end
      end else if (sb_q.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_out_valid: actual=%b required=1 at %0t", out_valid, $time);
        void'(sb_q.pop_front());
      end
      chk("sign_q", W'(sign_q), W'(hold.sign));
      chk("zero_q", W'(zero_q), W'(hold.zero));
      chk("abs_q", abs_q, hold.abs);
    end
  end

  logic [W-1:0] sweep_v[8] = '{16'h0F50, 16'hFF50, 16'hFFFF, 16'h7FFF,
                                16'h8000, 16'h0000, 16'hAAAA, 16'h55A5};
  logic         sweep_e[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [W-1:0] a;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    ans      = '0;

    // Clock held still: sign_ans must follow ans purely combinationally.
    for (int i = 0; i < 8; i++) begin
      ans = sweep_v[i];
      #2;
      chk("sweep_sign_ans", W'(sign_ans), W'(sweep_e[i]));
    end

    clk_run = 1'b1;
    mon_en  = 1'b1;
    step(1'b1, 1'b1, 16'hFFFF);
    chk("reset_sign_ans", W'(sign_ans), W'(1'b1));
    step(1'b1, 1'b1, 16'hFFFF);
    chk("reset_sign_ans", W'(sign_ans), W'(1'b1));

    step(1'b0, 1'b1, 16'hFF50);
    step(1'b0, 1'b1, 16'h0F50);
    step(1'b0, 1'b1, 16'h8000);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'h7FFF);

    step(1'b0, 1'b1, 16'hAAAA);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, W'($urandom));

    step(1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 16'hF00D);
    step(1'b0, 1'b1, 16'h8001);
    step(1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 16'h8000;
        1:       a = 16'h0000;
        2:       a = 16'h7FFF;
        3:       a = 16'hFFFF;
        default: a = W'($urandom);
      endcase
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), a);
    end

    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h5A5A);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", W'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
